// File: rtl/jk_bank_driver.sv
// -----------------------------------------------------------------------------
// jk_bank_driver
//
// Purpose:
//   Writes target words into a bank of WIDTH external JK flip-flops. For each
//   bit it picks J/K from the current Q feedback (set, reset or hold; toggle
//   is never used). It pulses J/K for exactly one clock and then reads the
//   bank back to check it. A mismatch is re-driven up to MAX_RETRY times.
//   Completion is reported with a one-cycle Done pulse, and Err qualifies it.
//
// Parameters:
//   WIDTH      number of JK flip-flops in the driven bank
//   MAX_RETRY  maximum re-drive attempts after a failed check (0 = none)
//
// Ports:
//   Clk          in   system clock (rising edge), shared with the bank
//   Rst          in   asynchronous reset, active-high
//   Tgt_data     in   target word to write into the bank
//   Tgt_valid    in   Tgt_data is valid
//   Tgt_ready    out  a target can be accepted this cycle (IDLE)
//   J, K         out  registered J/K inputs to the bank
//   Q_fb         in   Q outputs of the bank
//   Busy         out  high in every state except IDLE
//   Done         out  one-cycle pulse: write operation finished
//   Err          out  with Done: the final check failed
//
// Optional feature (macro JK_BANK_DRIVER_ERR_CNT_EN):
//   Err_count    out  [7:0] failed operations, saturating at 255
//   Retry_count  out  [7:0] re-drive attempts, saturating at 255
// -----------------------------------------------------------------------------
module jk_bank_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Tgt_data,
    input  logic             Tgt_valid,
    output logic             Tgt_ready,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] Q_fb,
    output logic             Busy,
    output logic             Done,
    output logic             Err
`ifdef JK_BANK_DRIVER_ERR_CNT_EN
    ,
    output logic [7:0]       Err_count,
    output logic [7:0]       Retry_count
`endif
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        DRIVE = 2'd2,
        CHECK = 2'd3
    } state_t;

    // The retry counter keeps at least one bit so MAX_RETRY = 0 still elaborates.
    localparam int             RW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]  MAX_R = RW'(MAX_RETRY);

    state_t           state, state_next;
    logic [WIDTH-1:0] target;
    logic [RW-1:0]    retry_cnt;
    logic             match;
    logic             can_retry;

    // Set a bit that is 0 but should be 1, and clear a bit that is 1 but
    // should be 0. Bits that already agree get J=K=0, so J=K=1 never occurs.
    function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] t);
        return t & ~q;
    endfunction

    function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] t);
        return q & ~t;
    endfunction

    assign match     = (Q_fb == target);
    assign can_retry = (retry_cnt < MAX_R);

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge no matter how the
    // statements are ordered.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= INIT;
        else     state <= state_next;
    end

    // ---------------------------------------------------------- next-state comb
    // NOTE: the default assignment at the top stops a latch being inferred on
    // any path that does not assign state_next.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = IDLE;
            IDLE:    if (Tgt_valid) state_next = DRIVE;
            DRIVE:   state_next = CHECK;
            CHECK:   state_next = (match || !can_retry) ? IDLE : DRIVE;
            default: state_next = INIT;
        endcase
    end

    // -------------------------------------------------------------- output comb
    always_comb begin
        Tgt_ready = 1'b0;
        Busy      = 1'b1;
        if (state == IDLE) begin
            Tgt_ready = 1'b1;
            Busy      = 1'b0;
        end
    end

    // ----------------------------------------------------------------- datapath
    // During reset J=0 and K=all ones, so the bank clears on any edge it sees.
    // NOTE: the target register is only read after IDLE has loaded it. It is
    // still reset so that simulation never carries X into the match compare.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            J         <= '0;
            K         <= '1;
            target    <= '0;
            retry_cnt <= '0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (state)
                INIT: begin
                    J <= '0;
                    K <= '0;
                end
                IDLE: begin
                    J <= '0;
                    K <= '0;
                    if (Tgt_valid) begin
                        target    <= Tgt_data;
                        retry_cnt <= '0;
                        J         <= exc_j(Q_fb, Tgt_data);
                        K         <= exc_k(Q_fb, Tgt_data);
                    end
                end
                DRIVE: begin
                    // The bank has taken J/K at this edge; release it to hold.
                    J <= '0;
                    K <= '0;
                end
                CHECK: begin
                    J <= '0;
                    K <= '0;
                    if (match) begin
                        Done <= 1'b1;
                    end else if (can_retry) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        J         <= exc_j(Q_fb, target);
                        K         <= exc_k(Q_fb, target);
                    end else begin
                        Done <= 1'b1;
                        Err  <= 1'b1;
                    end
                end
                default: begin
                    J <= '0;
                    K <= '1;
                end
            endcase
        end
    end

`ifdef JK_BANK_DRIVER_ERR_CNT_EN
    // ---------------------------------------------------------- status counters
    logic fail_evt, retry_evt;

    assign fail_evt  = (state == CHECK) && !match && !can_retry;
    assign retry_evt = (state == CHECK) && !match &&  can_retry;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Err_count   <= 8'd0;
            Retry_count <= 8'd0;
        end else begin
            if (fail_evt && (Err_count != 8'hFF))
                Err_count <= Err_count + 8'd1;
            if (retry_evt && (Retry_count != 8'hFF))
                Retry_count <= Retry_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_driver
//
// Self-checking bench for jk_bank_driver (WIDTH=8, MAX_RETRY=2). A behavioural
// JK bank is clocked by the same Clk and feeds Q_fb. The bench can preload the
// bank and can force selected bits to stay at 0. Inputs are driven and outputs
// are sampled on the falling edge of Clk.
// -----------------------------------------------------------------------------
module tb_jk_bank_driver;

    localparam int WIDTH = 8;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [WIDTH-1:0] Tgt_data;
    logic             Tgt_valid;
    logic             Tgt_ready;
    logic [WIDTH-1:0] J, K;
    logic [WIDTH-1:0] bank;
    logic             Busy, Done, Err;
`ifdef JK_BANK_DRIVER_ERR_CNT_EN
    logic [7:0]       Err_count, Retry_count;
`endif

    // Bank model controls
    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] stuck0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 Clk = ~Clk;

    // JK bank: Q+ = J&~Q | ~K&Q. Bits in stuck0 are held at 0.
    always @(posedge Clk) begin
        if (load_en) bank <= load_val;
        else         bank <= ((J & ~bank) | (~K & bank)) & ~stuck0;
    end

    jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(2)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Tgt_data   (Tgt_data),
        .Tgt_valid  (Tgt_valid),
        .Tgt_ready  (Tgt_ready),
        .J          (J),
        .K          (K),
        .Q_fb       (bank),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err)
`ifdef JK_BANK_DRIVER_ERR_CNT_EN
        ,
        .Err_count  (Err_count),
        .Retry_count(Retry_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic load_bank(input logic [WIDTH-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(negedge Clk);
        load_en  = 1'b0;
    endtask

    // Called on a falling edge in IDLE. Accepts t, then checks every DRIVE
    // (J/K = ej/ek), every CHECK, the Done cycle and the cycle after it.
    task automatic run_txn(input string tag, input logic [WIDTH-1:0] t,
                           input logic [WIDTH-1:0] ej, input logic [WIDTH-1:0] ek,
                           input int n_drives, input logic exp_err,
                           input logic [WIDTH-1:0] exp_bank);
        check({tag, "_ready_idle"}, Tgt_ready, 1);
        Tgt_valid = 1'b1;
        Tgt_data  = t;
        for (int d = 0; d < n_drives; d++) begin
            @(negedge Clk);
            if (d == 0) begin
                Tgt_valid = 1'b0;
                Tgt_data  = ~t;   // must not affect the operation in flight
            end
            check({tag, "_drive_j"}, J, ej);
            check({tag, "_drive_k"}, K, ek);
            check({tag, "_drive_busy_rdy"}, {Busy, Tgt_ready, Done}, 3'b100);
            @(negedge Clk);
            check({tag, "_check_jk"}, {J, K}, 16'h0000);
            check({tag, "_check_done"}, {Busy, Tgt_ready, Done}, 3'b100);
        end
        @(negedge Clk);
        check({tag, "_done"}, {Done, Err}, {1'b1, exp_err});
        check({tag, "_done_ready"}, {Tgt_ready, Busy}, 2'b10);
        check({tag, "_bank"}, bank, exp_bank);
        @(negedge Clk);
        check({tag, "_done_cleared"}, {Done, Err}, 2'b00);
    endtask

    typedef struct {
        logic [WIDTH-1:0] bank_init;
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] exp_j;
        logic [WIDTH-1:0] exp_k;
    } vec_t;

    vec_t vecs [5];

    initial begin
        // Excitation is hand-computed: J = t & ~q, K = q & ~t.
        vecs[0] = '{8'h00, 8'h3C, 8'h3C, 8'h00};
        vecs[1] = '{8'hF0, 8'h0F, 8'h0F, 8'hF0};
        vecs[2] = '{8'h5A, 8'h5A, 8'h00, 8'h00};
        vecs[3] = '{8'h0F, 8'hF0, 8'hF0, 8'h0F};
        vecs[4] = '{8'hA5, 8'h5A, 8'h5A, 8'hA5};

        Rst       = 1'b1;
        Tgt_valid = 1'b0;
        Tgt_data  = '0;
        load_en   = 1'b0;
        load_val  = '0;
        stuck0    = '0;

        // ---- reset values
        repeat (2) @(negedge Clk);
        check("rst_jk", {J, K}, 16'h00FF);
        check("rst_status", {Tgt_ready, Busy, Done, Err}, 4'b0100);

        // ---- reset release with the bank holding 0xA5
        load_bank(8'hA5);
        Rst = 1'b0;
        #1;
        check("init_jk", {J, K}, 16'h00FF);
        check("init_status", {Tgt_ready, Busy}, 2'b01);
        @(negedge Clk);
        check("init_bank_cleared", bank, 8'h00);
        check("idle_jk", {J, K}, 16'h0000);
        check("idle_status", {Tgt_ready, Busy, Done}, 3'b100);

        // ---- table-driven single writes
        for (int i = 0; i < 5; i++) begin
            load_bank(vecs[i].bank_init);
            run_txn($sformatf("vec%0d", i), vecs[i].target, vecs[i].exp_j,
                    vecs[i].exp_k, 1, 1'b0, vecs[i].target);
        end

        // ---- bit 3 stuck at 0: three drives, then Done with Err
        load_bank(8'h00);
        stuck0 = 8'h08;
        run_txn("stuck", 8'h08, 8'h08, 8'h00, 3, 1'b1, 8'h00);
        stuck0 = 8'h00;
`ifdef JK_BANK_DRIVER_ERR_CNT_EN
        check("err_count", Err_count, 1);
        check("retry_count", Retry_count, 2);
`endif

        // ---- back-to-back: Tgt_valid held high, data changed during DRIVE
        load_bank(8'h00);
        Tgt_valid = 1'b1;
        Tgt_data  = 8'h11;
        @(negedge Clk);
        check("b2b1_drive", {J, K}, 16'h1100);
        Tgt_data = 8'h22;              // ignored while not ready
        @(negedge Clk);
        check("b2b1_check", {J, K, Tgt_ready}, 17'h0);
        @(negedge Clk);
        check("b2b1_done", {Done, Err, Tgt_ready}, 3'b101);
        check("b2b1_bank", bank, 8'h11);
        @(negedge Clk);
        Tgt_valid = 1'b0;
        check("b2b2_drive", {J, K, Done}, {8'h22, 8'h11, 1'b0});
        @(negedge Clk);
        check("b2b2_check", {Done, Tgt_ready}, 2'b00);
        @(negedge Clk);
        check("b2b2_done", {Done, Err}, 2'b10);
        check("b2b2_bank", bank, 8'h22);
        @(negedge Clk);

        // ---- reset asserted during CHECK
        load_bank(8'h00);
        Tgt_valid = 1'b1;
        Tgt_data  = 8'h3C;
        @(negedge Clk);
        Tgt_valid = 1'b0;
        @(negedge Clk);
        check("mid_in_check", {Busy, Tgt_ready}, 2'b10);
        Rst = 1'b1;
        #1;
        check("mid_rst_jk", {J, K}, 16'h00FF);
        check("mid_rst_status", {Done, Err, Tgt_ready, Busy}, 4'b0001);
        @(negedge Clk);
        check("mid_rst_no_done", Done, 0);
        Rst = 1'b0;
        #1;
        check("mid_init", {Busy, Tgt_ready, Done}, 3'b100);
        @(negedge Clk);
        check("mid_idle", {Busy, Tgt_ready, Done}, 3'b010);
        check("mid_bank_cleared", bank, 8'h00);
        @(negedge Clk);
        check("mid_no_stale_done", Done, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
